// File: rtl/io_input_cond.sv
// io_input_cond: conditions asynchronous board switches and keys.
// Each channel is polarity-corrected, passed through a 2-flop synchroniser
// and debounced. The block then produces edge pulses and sticky event flags.
//
// Parameters:
//   NUM_CH       number of input channels (18 switches + 5 keys by default)
//   DEBOUNCE_CYC stable cycles before a new level is accepted (1 .. 2^24-1)
//   INV_MASK     channels inverted before synchronisation (active-low keys)
//   EDGE_SEL     edges that set event_o: 0 = rise, 1 = fall, 2 = both
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset; release is synchronised internally
//   raw_i    asynchronous board inputs
//   clr_i    write-1-to-clear strobe for event_o
//   level_o  debounced, polarity-corrected level
//   rise_o   one-cycle pulse on each 0->1 transition of level_o
//   fall_o   one-cycle pulse on each 1->0 transition of level_o
//   event_o  sticky edge flags
//   irq_o    registered OR of event_o (only when IO_COND_IRQ_EN is defined)
//
// Build option: define IO_COND_IRQ_EN to add the irq_o port and its OR logic.

module io_input_cond #(
    parameter int unsigned       NUM_CH       = 23,
    parameter int unsigned       DEBOUNCE_CYC = 1000000,
    parameter logic [NUM_CH-1:0] INV_MASK     = NUM_CH'(23'h7C0000),
    parameter int unsigned       EDGE_SEL     = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] raw_i,
    input  logic [NUM_CH-1:0] clr_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] event_o
`ifdef IO_COND_IRQ_EN
    ,
    output logic              irq_o
`endif
);

    localparam int unsigned       CNT_W    = 24;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic              SEL_RISE = (EDGE_SEL != 1);
    localparam logic              SEL_FALL = (EDGE_SEL != 0);

    logic              rst_meta_q;
    logic              rst_sync_n;
    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] level_d;
    logic [NUM_CH-1:0] rise_d;
    logic [NUM_CH-1:0] fall_d;
    logic [NUM_CH-1:0] event_d;

    // Reset synchroniser: asserts asynchronously, releases on the second edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_meta_q <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_n <= rst_meta_q;
        end
    end

    // Input synchroniser. Polarity is corrected in front of the first flop so
    // that nothing sits between the two flops. Both flops release together
    // with the reset synchroniser, so the debounce logic first sees real data
    // on its first active edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_i ^ INV_MASK;
            sync2_q <= sync1_q;
        end
    end

    // Debounce, edge detection and sticky event next-state.
    always_comb begin
        level_d = level_o;
        rise_d  = '0;
        fall_d  = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            cnt_d[n] = '0;
            if (sync2_q[n] != level_o[n]) begin
                // The >= compare keeps the counter from ever passing CNT_LAST.
                if (cnt_q[n] >= CNT_LAST) begin
                    level_d[n] = sync2_q[n];
                    rise_d[n]  = sync2_q[n];
                    fall_d[n]  = ~sync2_q[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + CNT_W'(1);
                end
            end
        end
        // A set wins over a clear that arrives on the same cycle.
        event_d = (event_o & ~clr_i)
                | ({NUM_CH{SEL_RISE}} & rise_o)
                | ({NUM_CH{SEL_FALL}} & fall_o);
    end

    // State registers, held in reset until the synchronised reset releases.
    always_ff @(posedge clk_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            cnt_q   <= '{default: '0};
            level_o <= '0;
            rise_o  <= '0;
            fall_o  <= '0;
            event_o <= '0;
        end else begin
            cnt_q   <= cnt_d;
            level_o <= level_d;
            rise_o  <= rise_d;
            fall_o  <= fall_d;
            event_o <= event_d;
        end
    end

`ifdef IO_COND_IRQ_EN
    // Interrupt request: registered OR of all sticky flags.
    always_ff @(posedge clk_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |event_o;
        end
    end
`endif

endmodule

// File: tb/tb_io_input_cond.sv
// Scoreboard bench for io_input_cond (DEBOUNCE_CYC=4, NUM_CH=23, 20 ns clock).
// The driver applies directed and random stimulus, steps a reference model
// at every rising edge and queues the expected outputs. A monitor pops and
// compares one entry on every falling edge.

module tb_io_input_cond;

    localparam int unsigned       NCH = 23;
    localparam int unsigned       DEB = 4;
    localparam logic [NCH-1:0]    INV = 23'h7C0000;

    typedef struct packed {
        logic [NCH-1:0] level;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
        logic [NCH-1:0] evt;
        logic           irq;
    } exp_t;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic [NCH-1:0] raw_i = '0;
    logic [NCH-1:0] clr_i = '0;
    logic [NCH-1:0] level_o;
    logic [NCH-1:0] rise_o;
    logic [NCH-1:0] fall_o;
    logic [NCH-1:0] event_o;
    logic           irq_act;

    int n_vec = 0;
    int n_err = 0;

    exp_t exp_q[$];

    // Reference model state.
    logic [NCH-1:0] m_level = '0;
    logic [NCH-1:0] m_rise  = '0;
    logic [NCH-1:0] m_fall  = '0;
    logic [NCH-1:0] m_evt   = '0;
    logic           m_irq   = 1'b0;
    logic [NCH-1:0] raw_hist[$];   // corrected raw samples of the last two edges
    logic [NCH-1:0] cmp_hist[$];   // synchronised values seen by the debouncer

    always #10 clk_i = ~clk_i;

    io_input_cond #(
        .NUM_CH      (NCH),
        .DEBOUNCE_CYC(DEB),
        .INV_MASK    (INV),
        .EDGE_SEL    (2)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .raw_i  (raw_i),
        .clr_i  (clr_i),
        .level_o(level_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
        .event_o(event_o)
`ifdef IO_COND_IRQ_EN
        ,
        .irq_o  (irq_act)
`endif
    );

`ifndef IO_COND_IRQ_EN
    assign irq_act = 1'b0;
`endif

    // Model behaviour: a level flips once the last DEB synchronised values
    // all disagree with it. The synchronised value is the corrected raw input
    // from two edges earlier. Events set from the previous pulses, irq follows
    // the previous events.
    task automatic model_step();
        logic [NCH-1:0] flip;
        logic [NCH-1:0] new_evt;
        logic           new_irq;
        logic           all_diff;
        if (!rst_ni) begin
            m_level = '0; m_rise = '0; m_fall = '0; m_evt = '0; m_irq = 1'b0;
            raw_hist.delete();
            cmp_hist.delete();
        end else begin
            new_evt = (m_evt & ~clr_i) | m_rise | m_fall;
            new_irq = |m_evt;
            flip    = '0;
            if (raw_hist.size() >= 2) begin
                cmp_hist.push_back(raw_hist[raw_hist.size() - 2]);
                if (cmp_hist.size() > DEB) void'(cmp_hist.pop_front());
            end
            if (cmp_hist.size() == DEB) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < DEB; k++)
                        if (cmp_hist[k][ch] == m_level[ch]) all_diff = 1'b0;
                    flip[ch] = all_diff;
                end
            end
            m_rise  = flip & ~m_level;
            m_fall  = flip & m_level;
            m_level = m_level ^ flip;
            m_evt   = new_evt;
            m_irq   = new_irq;
            raw_hist.push_back(raw_i ^ INV);
            if (raw_hist.size() > 2) void'(raw_hist.pop_front());
        end
    endtask

    task automatic step_and_push();
        exp_t e;
        model_step();
        e.level = m_level; e.rise = m_rise; e.fall = m_fall;
        e.evt = m_evt; e.irq = m_irq;
        exp_q.push_back(e);
    endtask

    // One clock: apply inputs, model the edge, return at edge + 2 ns.
    task automatic cycle(input logic [NCH-1:0] raw, input logic [NCH-1:0] clr);
        raw_i = raw;
        clr_i = clr;
        @(posedge clk_i);
        step_and_push();
        #2;
    endtask

    // Reset pulse asserted just after a monitor sample, spanning two edges.
    task automatic rst_pulse();
        #10;
        rst_ni = 1'b0;
        @(posedge clk_i);
        step_and_push();
        #2;
        @(posedge clk_i);
        step_and_push();
        #13;
        rst_ni = 1'b1;
        @(posedge clk_i);
        step_and_push();
        #2;
    endtask

    task automatic spot(input string name, input logic [NCH-1:0] act,
                        input logic [NCH-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: compare DUT outputs to the queued expectation on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (level_o !== e.level || rise_o !== e.rise || fall_o !== e.fall ||
                    event_o !== e.evt
`ifdef IO_COND_IRQ_EN
                    || irq_act !== e.irq
`endif
                    ) begin
                    n_err++;
                    $display("FAIL scoreboard t=%0t: level %h/%h rise %h/%h fall %h/%h event %h/%h irq %b/%b (got/expected)",
                             $time, level_o, e.level, rise_o, e.rise, fall_o, e.fall,
                             event_o, e.evt, irq_act, e.irq);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NCH-1:0] cur;
        logic [NCH-1:0] tgl;
        logic [NCH-1:0] clr;

        // Reset held for 55 ns with raw_i = 0.
        cur = '0;
        cycle(cur, '0);
        cycle(cur, '0);
        cycle(cur, '0);
        spot("reset_level", level_o, '0);
        spot("reset_event", event_o, '0);
        #3;
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) cycle(cur, '0);
        spot("startup_level", level_o, 23'h7C0000);
        spot("startup_rise", rise_o, 23'h7C0000);
        cycle(cur, '0);
        spot("startup_rise_gone", rise_o, '0);
        spot("startup_event", event_o, 23'h7C0000);

        // Clean step on channel 0.
        cur = 23'h000001;
        for (int i = 0; i < 5; i++) cycle(cur, '0);
        spot("ch0_not_yet", NCH'(level_o[0]), '0);
        cycle(cur, '0);
        spot("ch0_level", NCH'(level_o[0]), NCH'(1));
        spot("ch0_rise", NCH'(rise_o[0]), NCH'(1));
        cycle(cur, '0);
        spot("ch0_event", NCH'(event_o[0]), NCH'(1));

        // Three-cycle glitch on channel 5 is rejected.
        for (int i = 0; i < 3; i++) cycle(cur | 23'h000020, '0);
        for (int i = 0; i < 8; i++) cycle(cur, '0);
        spot("ch5_glitch_level", NCH'(level_o[5]), '0);
        spot("ch5_glitch_event", NCH'(event_o[5]), '0);

        // Clear versus set on channel 0.
        cur = '0;
        for (int i = 0; i < 8; i++) cycle(cur, '0);
        cycle(cur, 23'h000001);
        spot("ch0_cleared", NCH'(event_o[0]), '0);
        cur = 23'h000001;
        for (int i = 0; i < 6; i++) cycle(cur, '0);
        spot("ch0_rise_again", NCH'(rise_o[0]), NCH'(1));
        cycle(cur, 23'h000001);
        spot("ch0_set_wins", NCH'(event_o[0]), NCH'(1));
        cycle(cur, 23'h000001);
        spot("ch0_clear_alone", NCH'(event_o[0]), '0);

        // Switches to 18'h3ABCF while key 18 is released.
        cur = 23'h07ABCF;
        for (int i = 0; i < 6; i++) cycle(cur, '0);
        spot("multi_level", level_o, 23'h7BABCF);
        spot("multi_rise", rise_o, 23'h03ABCE);
        spot("multi_fall", fall_o, 23'h040000);
        for (int i = 0; i < 3; i++) cycle(cur, '0);

        // Reset in the middle of a count on channel 2.
        cur = cur & ~23'h000004;
        for (int i = 0; i < 4; i++) cycle(cur, '0);
        rst_pulse();
        spot("midreset_level", level_o, '0);
        spot("midreset_rise", rise_o, '0);
        cur = cur | 23'h000004;
        for (int i = 0; i < 5; i++) cycle(cur, '0);
        spot("ch2_restep_early", NCH'(level_o[2]), '0);
        cycle(cur, '0);
        spot("ch2_restep_level", NCH'(level_o[2]), NCH'(1));

        // Random toggles (sparse per bit) and clears, with one reset.
        for (int i = 0; i < 400; i++) begin
            tgl = NCH'($urandom & $urandom & $urandom & $urandom);
            clr = NCH'($urandom & $urandom & $urandom);
            cur = cur ^ tgl;
            if (i == 200) rst_pulse();
            else cycle(cur, clr);
        end
        for (int i = 0; i < 8; i++) cycle(cur, '0);

        @(negedge clk_i);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
